alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, arbitration policy: 1 = round-robin, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_op  input  4  requester 0 ALU operation code.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_op, req1_a, req1_b, req1_ready: same widths and meaning for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_id  output  1  requester that owns the result (0 or 1).
REQ-011 rsp_result  output  32  ALU result.
REQ-012 rsp_zero  output  1  ALU zero flag for rsp_result.
REQ-013 rsp_ready  input  1  consumer takes the result this cycle.

Function
REQ-014 Operation codes SHALL be AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, MULT 0101; every other code yields result 0, zero 1.
REQ-015 The block SHALL contain one shared 32-bit ALU instance and a three-state FSM: IDLE, EXEC, RESP.
REQ-016 IDLE: if any reqN_valid is high, the block SHALL grant one requester, assert its reqN_ready combinationally in that cycle only, capture op/a/b/id into registers and move to EXEC; otherwise stay in IDLE.
REQ-017 At most one reqN_ready SHALL be high in any cycle; reqN_ready SHALL be low in EXEC and RESP.
REQ-018 Both valid with RR_EN=1: grant the requester not granted last; first grant after reset goes to requester 0.
REQ-019 Both valid with RR_EN=0: requester 0 always wins.
REQ-020 EXEC: the ALU SHALL evaluate the captured registers; result and zero SHALL be registered into rsp_result/rsp_zero; FSM moves to RESP.
REQ-021 RESP: rsp_valid SHALL be high; rsp_result, rsp_zero, rsp_id SHALL hold stable until rsp_ready is high; on rsp_valid&&rsp_ready FSM returns to IDLE.
REQ-022 Latency: acceptance at edge N SHALL give rsp_valid high from cycle N+2; peak throughput one operation per 3 cycles.
REQ-023 Requesters SHALL hold valid/op/a/b stable until ready; a requester dropping valid before ready loses nothing (no capture occurs).
REQ-024 The round-robin pointer SHALL update at grant time, not at response time.
REQ-025 Requests arriving during EXEC or RESP SHALL wait; no request is dropped or reordered per requester.

Reset
REQ-026 reset low SHALL force, asynchronously: FSM IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, RR pointer to requester 0, captured registers 0.
REQ-027 Reset during EXEC or RESP SHALL abandon the operation with no response issued; req*_ready SHALL be 0 while reset is low.

Structure
REQ-028 Opcode constants, FSM state encoding and requester-id width SHALL live in a shared package used by the ALU and this block.
REQ-029 The existing 32-bit ALU module SHALL be instantiated unmodified as the single sub-module; arbitration and FSM stay in alu_arbiter.

Verification
REQ-030 req0 ADD a=5 b=7, rsp_ready=1 -> req0_ready in acceptance cycle, rsp_valid 2 cycles later, rsp_result=12, rsp_zero=0, rsp_id=0.
REQ-031 req1 SUB a=3 b=3 -> rsp_result=0, rsp_zero=1, rsp_id=1.
REQ-032 Both valid continuously, RR_EN=1, four ops -> rsp_id sequence 0,1,0,1; RR_EN=0 -> 0,0,0,0.
REQ-033 rsp_ready held low 4 cycles in RESP with NOR a=0 b=0 -> rsp_valid stays high, rsp_result=32'hFFFFFFFF stable throughout, both req*_ready low.
REQ-034 reset pulsed low during EXEC -> all outputs 0 immediately, no rsp_valid afterward; next req1 OR a=1 b=2 -> result 3.
REQ-035 req0 op 4'b1111 a=9 b=9 -> rsp_result=0, rsp_zero=1.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states
// and requester-id type, plus the zero-flag helper used by the ALU.
package alu_arbiter_pkg;

  localparam int ID_W = 1;
  typedef logic [ID_W-1:0] id_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_NOR  = 4'b0010,
    OP_ADD  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_MULT = 4'b0101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  function automatic logic is_zero(input logic [31:0] value);
    return (value == 32'd0);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU shared by both requesters; undefined
// opcodes produce a zero result.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  // Operation select; MULT keeps the low 32 bits of the product.
  always_comb begin
    result = 32'd0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOR:  result = ~(a | b);
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MULT: result = a * b;
      default: result = 32'd0;
    endcase
  end

  assign zero = is_zero(result);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: grants in IDLE, evaluates
// in EXEC and holds the registered response in RESP until it is consumed.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  input  logic        rsp_ready
);

  arb_state_e  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  id_t         id_q, id_d;
  id_t         rr_next_q, rr_next_d;
  logic        rsp_valid_q, rsp_valid_d;
  id_t         rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;

  logic        grant0_s, grant1_s;
  logic [31:0] alu_result_s;
  logic        alu_zero_s;

  alu_arbiter_alu u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result_s),
    .zero   (alu_zero_s)
  );

  // Grant decision; gated by reset so no handshake can complete while held in reset.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_q == ST_IDLE) && reset) begin
      if (req0_valid && req1_valid) begin
        if (RR_EN && (rr_next_q == 1'b1)) begin
          grant1_s = 1'b1;
        end else begin
          grant0_s = 1'b1;
        end
      end else if (req0_valid) begin
        grant0_s = 1'b1;
      end else if (req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Next-state and datapath capture; the RR pointer moves at grant time.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rr_next_d    = rr_next_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0_s || grant1_s) begin
          op_d      = grant1_s ? req1_op : req0_op;
          a_d       = grant1_s ? req1_a : req0_a;
          b_d       = grant1_s ? req1_b : req0_b;
          id_d      = id_t'(grant1_s);
          rr_next_d = id_t'(~grant1_s);
          state_d   = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result_s;
        rsp_zero_d   = alu_zero_s;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      op_q         <= 4'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      id_q         <= 1'b0;
      rr_next_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rr_next_q    <= rr_next_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, and a random
// run against a transaction-level reference model (round-robin instance).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic        rr_ready0, rr_ready1, rr_rv, rr_id, rr_zero;
  logic [31:0] rr_res;
  logic        fp_ready0, fp_ready1, fp_rv, fp_id, fp_zero;
  logic [31:0] fp_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(rr_ready0),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(rr_ready1),
    .rsp_valid(rr_rv), .rsp_id(rr_id), .rsp_result(rr_res), .rsp_zero(rr_zero), .rsp_ready(rsp_ready)
  );

  alu_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(fp_ready0),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(fp_ready1),
    .rsp_valid(fp_rv), .rsp_id(fp_id), .rsp_result(fp_res), .rsp_zero(fp_zero), .rsp_ready(rsp_ready)
  );

  typedef struct {
    logic        who;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
  } exp_t;

  localparam int NV = 11;
  vec_t vecs [NV];
  exp_t exp_q [$];

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return ~(a | b);
      4'd3:    return a + b;
      4'd4:    return a - b;
      4'd5:    return a * b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic who, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (who) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // One transaction with rsp_ready high; called just after a rising edge with both DUTs idle.
  task automatic run_single(input logic who, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] res, input logic zero);
    rsp_ready = 1'b1;
    drive(who, op, a, b);
    @(negedge clk);
    chk("accept_ready_rr", {31'd0, who ? rr_ready1 : rr_ready0}, 32'd1);
    chk("other_ready_rr", {31'd0, who ? rr_ready0 : rr_ready1}, 32'd0);
    chk("accept_ready_fp", {31'd0, who ? fp_ready1 : fp_ready0}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("exec_rsp_valid", {31'd0, rr_rv}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rsp_valid", {31'd0, rr_rv}, 32'd1);
    chk("rsp_id", {31'd0, rr_id}, {31'd0, who});
    chk("rsp_result", rr_res, res);
    chk("rsp_zero", {31'd0, rr_zero}, {31'd0, zero});
    chk("rsp_result_fp", fp_res, res);
    @(posedge clk); #1;
  endtask

  int   rr_ids [4];
  int   fp_ids [4];
  int   n;
  bit   free;
  int   age;
  logic last_id, g0, g1, exp_id;

  initial begin
    vecs[0]  = '{1'b0, 4'b0011, 32'd5,          32'd7,          32'd12,         1'b0};
    vecs[1]  = '{1'b1, 4'b0100, 32'd3,          32'd3,          32'd0,          1'b1};
    vecs[2]  = '{1'b0, 4'b0000, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'h0F0F_0000,  1'b0};
    vecs[3]  = '{1'b1, 4'b0001, 32'd1,          32'd2,          32'd3,          1'b0};
    vecs[4]  = '{1'b0, 4'b0010, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0};
    vecs[5]  = '{1'b1, 4'b0101, 32'd6,          32'd7,          32'd42,         1'b0};
    vecs[6]  = '{1'b0, 4'b0101, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1};
    vecs[7]  = '{1'b1, 4'b0011, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
    vecs[8]  = '{1'b0, 4'b0100, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
    vecs[9]  = '{1'b0, 4'b1111, 32'd9,          32'd9,          32'd0,          1'b1};
    vecs[10] = '{1'b1, 4'b0110, 32'd4,          32'd4,          32'd0,          1'b1};

    // Reset state with both requesters asking: nothing may be granted.
    reset = 1'b0;
    rsp_ready = 1'b1;
    idle_inputs();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", {31'd0, rr_ready0}, 32'd0);
    chk("rst_ready1", {31'd0, rr_ready1}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rr_rv}, 32'd0);
    chk("rst_rsp_id", {31'd0, rr_id}, 32'd0);
    chk("rst_rsp_result", rr_res, 32'd0);
    chk("rst_rsp_zero", {31'd0, rr_zero}, 32'd0);
    chk("rst_fp_ready0", {31'd0, fp_ready0}, 32'd0);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++)
      run_single(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero);

    // Response held under back-pressure; a waiting requester stays unserved.
    rsp_ready = 1'b0;
    drive(1'b0, 4'b0010, 32'd0, 32'd0);
    @(negedge clk);
    chk("bp_accept", {31'd0, rr_ready0}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    drive(1'b1, 4'b0011, 32'd1, 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'd0, rr_rv}, 32'd1);
      chk("bp_rsp_result", rr_res, 32'hFFFF_FFFF);
      chk("bp_rsp_zero", {31'd0, rr_zero}, 32'd0);
      chk("bp_ready0", {31'd0, rr_ready0}, 32'd0);
      chk("bp_ready1", {31'd0, rr_ready1}, 32'd0);
      @(posedge clk); #1;
    end
    idle_inputs();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {31'd0, rr_rv}, 32'd1);
    @(posedge clk); #1;

    // Reset in EXEC abandons the operation.
    drive(1'b0, 4'b0011, 32'd5, 32'd7);
    @(negedge clk);
    chk("rx_accept", {31'd0, rr_ready0}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("rx_rsp_valid", {31'd0, rr_rv}, 32'd0);
    chk("rx_rsp_result", rr_res, 32'd0);
    chk("rx_rsp_zero", {31'd0, rr_zero}, 32'd0);
    chk("rx_rsp_id", {31'd0, rr_id}, 32'd0);
    chk("rx_fp_rsp_result", fp_res, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rx_no_rsp", {31'd0, rr_rv}, 32'd0);
    end
    @(posedge clk); #1;
    run_single(1'b1, 4'b0001, 32'd1, 32'd2, 32'd3, 1'b0);

    // Both requesters valid continuously: grant order per policy.
    do_reset();
    rsp_ready = 1'b1;
    drive(1'b0, 4'b0011, 32'd1, 32'd1);
    drive(1'b1, 4'b0011, 32'd2, 32'd2);
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (rr_rv) begin
        rr_ids[n] = int'(rr_id);
        fp_ids[n] = int'(fp_id);
        n++;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    chk("both_count", n, 32'd4);
    for (int k = 0; k < n; k++) begin
      chk("rr_id_seq", rr_ids[k], (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("fp_id_seq", fp_ids[k], 32'd0);
    end

    // Random traffic against the transaction-level model (round-robin instance).
    do_reset();
    free = 1'b1;
    age = -1;
    last_id = 1'b1;
    exp_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      g0 = rr_ready0;
      g1 = rr_ready1;
      chk("rnd_one_ready", {31'd0, g0 & g1}, 32'd0);
      chk("rnd_grant_any", {31'd0, g0 | g1}, {31'd0, free && (req0_valid || req1_valid)});
      if (g0 | g1) begin
        exp_id = (req0_valid && req1_valid) ? ~last_id : req1_valid;
        chk("rnd_grant_id", {31'd0, g1}, {31'd0, exp_id});
        last_id = g1;
        exp_q.push_back(g1 ? exp_t'{1'b1, alu_model(req1_op, req1_a, req1_b)}
                           : exp_t'{1'b0, alu_model(req0_op, req0_a, req0_b)});
        free = 1'b0;
        age = 0;
      end
      chk("rnd_rsp_valid", {31'd0, rr_rv}, {31'd0, age >= 2});
      if (rr_rv && exp_q.size() > 0) begin
        chk("rnd_rsp_id", {31'd0, rr_id}, {31'd0, exp_q[0].id});
        chk("rnd_rsp_result", rr_res, exp_q[0].res);
        chk("rnd_rsp_zero", {31'd0, rr_zero}, {31'd0, exp_q[0].res == 32'd0});
      end
      if (rr_rv && rsp_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        free = 1'b1;
        age = -1;
      end else if (age >= 0) begin
        age++;
      end
      @(posedge clk); #1;
      if (g0 || !req0_valid || $urandom_range(0, 99) < 5) begin
        req0_valid = ($urandom_range(0, 99) < 60);
        req0_op = 4'($urandom_range(0, 7));
        req0_a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
        req0_b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
      end
      if (g1 || !req1_valid || $urandom_range(0, 99) < 5) begin
        req1_valid = ($urandom_range(0, 99) < 60);
        req1_op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
        req1_a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
        req1_b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
      end
      rsp_ready = ($urandom_range(0, 99) < 65);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
